// File: rtl/prores_header_pkg.sv
// Shared definitions for the ProRes header emitters.
//   hdr_state_e   : emitter FSM states (IDLE, EMIT, FLUSH)
//   pic_hdr_cfg_t : per-picture fields latched on start
//   hdr_field_t   : one {val, size} beat for the bit writer
//   pic_hdr_field : picture-header field table, indexed 0..PIC_HDR_FIELDS-1
package prores_header_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EMIT  = 2'd1,
    FLUSH = 2'd2
  } hdr_state_e;

  localparam int unsigned PIC_HDR_FIELDS = 7;

  localparam int unsigned FW_HDR_SIZE   = 5;
  localparam int unsigned FW_RSVD0      = 3;
  localparam int unsigned FW_PIC_SIZE   = 32;
  localparam int unsigned FW_SLICE_NUM  = 16;
  localparam int unsigned FW_RSVD1      = 2;
  localparam int unsigned FW_LOG2_SLICE = 2;
  localparam int unsigned FW_RSVD2      = 4;

  typedef struct packed {
    logic [31:0] picture_size;
    logic [15:0] slice_num;
    logic [1:0]  log2_slice_mb;
  } pic_hdr_cfg_t;

  typedef struct packed {
    logic [31:0] val;
    logic [5:0]  size;
  } hdr_field_t;

  function automatic hdr_field_t pic_hdr_field(input logic [2:0]   index,
                                               input pic_hdr_cfg_t cfg,
                                               input logic [4:0]   hdr_size_bytes);
    hdr_field_t f;
    f.val  = '0;
    f.size = '0;
    case (index)
      3'd0: begin f.val = {27'd0, hdr_size_bytes};    f.size = 6'(FW_HDR_SIZE);   end
      3'd1: begin f.val = '0;                         f.size = 6'(FW_RSVD0);      end
      3'd2: begin f.val = cfg.picture_size;           f.size = 6'(FW_PIC_SIZE);   end
      3'd3: begin f.val = {16'd0, cfg.slice_num};     f.size = 6'(FW_SLICE_NUM);  end
      3'd4: begin f.val = '0;                         f.size = 6'(FW_RSVD1);      end
      3'd5: begin f.val = {30'd0, cfg.log2_slice_mb}; f.size = 6'(FW_LOG2_SLICE); end
      3'd6: begin f.val = '0;                         f.size = 6'(FW_RSVD2);      end
      default: begin f.val = '0;                      f.size = '0;                end
    endcase
    return f;
  endfunction

endpackage

// File: rtl/picture_header_gen.sv
// ProRes picture-header emitter: streams the header as (val, size_of_bit)
// beats to the bit writer, with ready backpressure and an optional flush beat.
//   clock, reset_n      : clock, asynchronous active-low reset
//   start               : header request (accepted in IDLE only)
//   picture_size, slice_num, log2_slice_mb : per-picture fields, latched on start
//   out_ready           : bit writer accepts the current beat
//   output_enable, val, size_of_bit, flush_bit : beat to the bit writer
//   busy, done, start_err : status (done/start_err are one-cycle pulses)
module picture_header_gen
  import prores_header_pkg::*;
#(
  parameter int unsigned VAL_WIDTH      = 64,
  parameter int unsigned SIZE_WIDTH     = 64,
  parameter int unsigned HDR_SIZE_BYTES = 8,
  parameter bit          FLUSH_AT_END   = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [31:0]           picture_size,
  input  logic [15:0]           slice_num,
  input  logic [1:0]            log2_slice_mb,
  input  logic                  out_ready,
  output logic                  output_enable,
  output logic [VAL_WIDTH-1:0]  val,
  output logic [SIZE_WIDTH-1:0] size_of_bit,
  output logic                  flush_bit,
  output logic                  busy,
  output logic                  done,
  output logic                  start_err
);

  localparam logic [2:0] LAST_IDX = 3'(PIC_HDR_FIELDS - 1);
  localparam logic [4:0] HDR_SIZE = 5'(HDR_SIZE_BYTES);

  hdr_state_e      state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  pic_hdr_cfg_t    cfg_q, cfg_d;
  logic            oe_q, oe_d;
  logic [VAL_WIDTH-1:0]  val_q, val_d;
  logic [SIZE_WIDTH-1:0] size_q, size_d;
  logic            flush_q, flush_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            start_err_q, start_err_d;

  pic_hdr_cfg_t    cfg_in;
  pic_hdr_cfg_t    fld_cfg;
  logic [2:0]      fld_idx;
  hdr_field_t      fld;

  assign cfg_in = {picture_size, slice_num, log2_slice_mb};

  // The field mux always looks one beat ahead: beat 0 of the live inputs while
  // idle (so it can be registered on the accepting edge), otherwise the beat
  // following the one currently presented, from the latched config.
  always_comb begin
    fld_idx = '0;
    fld_cfg = cfg_in;
    if (state_q != IDLE) begin
      fld_idx = idx_q + 3'd1;
      fld_cfg = cfg_q;
    end
    fld = pic_hdr_field(fld_idx, fld_cfg, HDR_SIZE);
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cfg_d       = cfg_q;
    oe_d        = oe_q;
    val_d       = val_q;
    size_d      = size_q;
    flush_d     = flush_q;
    done_d      = 1'b0;
    start_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        oe_d    = 1'b0;
        val_d   = '0;
        size_d  = '0;
        flush_d = 1'b0;
        if (start) begin
          cfg_d   = cfg_in;
          idx_d   = '0;
          oe_d    = 1'b1;
          val_d   = VAL_WIDTH'(fld.val);
          size_d  = SIZE_WIDTH'(fld.size);
          state_d = EMIT;
        end
      end

      EMIT: begin
        start_err_d = start;
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d  = '0;
            val_d  = '0;
            size_d = '0;
            if (FLUSH_AT_END) begin
              flush_d = 1'b1;
              state_d = FLUSH;
            end else begin
              oe_d    = 1'b0;
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end else begin
            idx_d  = idx_q + 3'd1;
            val_d  = VAL_WIDTH'(fld.val);
            size_d = SIZE_WIDTH'(fld.size);
          end
        end
      end

      FLUSH: begin
        start_err_d = start;
        if (out_ready) begin
          oe_d    = 1'b0;
          flush_d = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        idx_d   = '0;
        oe_d    = 1'b0;
        val_d   = '0;
        size_d  = '0;
        flush_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cfg_q       <= '0;
      oe_q        <= 1'b0;
      val_q       <= '0;
      size_q      <= '0;
      flush_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      start_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cfg_q       <= cfg_d;
      oe_q        <= oe_d;
      val_q       <= val_d;
      size_q      <= size_d;
      flush_q     <= flush_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      start_err_q <= start_err_d;
    end
  end

  assign output_enable = oe_q;
  assign val           = val_q;
  assign size_of_bit   = size_q;
  assign flush_bit     = flush_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign start_err     = start_err_q;

endmodule

// File: doc/picture_header_gen.md
Name: picture_header_gen

Overview:
Parameterised ProRes picture-header emitter. It produces the header as a sequence of (val, size_of_bit) beats that feed the downstream bit writer. Per-picture fields (picture_size, slice count, log2 slice size) are latched on a start pulse rather than hard-wired. A ready handshake supports writer backpressure, and an optional trailing flush beat can be enabled. The block sits between the frame controller and the bit writer, ahead of the slice-header and slice-data emitters.

Parameters:
VAL_WIDTH, 64, width of val port; must be >= 32; field values are zero-extended.
SIZE_WIDTH, 64, width of size_of_bit port.
HDR_SIZE_BYTES, 8, value emitted in the 5-bit picture_header_size field; must be < 32.
FLUSH_AT_END, 0, when 1, append a flush beat (val=0, size_of_bit=0, flush_bit=1) after the last field.

Ports:
clock  in  1  single clock domain; all state updates on the rising edge.
reset_n  in  1  asynchronous, active-low reset.
start  in  1  one-cycle request to emit a header; accepted only in IDLE.
picture_size  in  32  picture size field value; latched on accepted start.
slice_num  in  16  slice count field value; latched on accepted start.
log2_slice_mb  in  2  log2_desired_slice_size_in_mb; latched on accepted start.
out_ready  in  1  bit writer can accept the current beat.
output_enable  out  1  beat valid.
val  out  VAL_WIDTH  field value, zero-extended.
size_of_bit  out  SIZE_WIDTH  field bit count.
flush_bit  out  1  flush request; high only on the flush beat.
busy  out  1  high from the cycle after start acceptance until done.
done  out  1  one-cycle pulse after the last beat is accepted.
start_err  out  1  one-cycle pulse when start arrives while not IDLE.

Behaviour:
- Reset (asynchronous, any time, including mid-header):
  - All outputs go to 0; state goes to IDLE; field index goes to 0; latched config goes to 0.
  - No partial header resumes after reset.
- All outputs are registered.
- States and transitions:
  - IDLE: on start, latch config, load beat 0 into the output registers, assert output_enable, go to EMIT.
    - Latency: start at edge N puts beat 0 on the outputs after edge N+1.
  - EMIT: field index 0..6; beat order:
    - 0: val=HDR_SIZE_BYTES, size=5
    - 1: val=0, size=3
    - 2: val=picture_size, size=32
    - 3: val=slice_num, size=16
    - 4: val=0, size=2
    - 5: val=log2_slice_mb, size=2
    - 6: val=0, size=4
    - Total header is 64 bits.
  - FLUSH (only when FLUSH_AT_END=1): one beat with val=0, size=0, flush_bit=1.
  - DONE path: after the last beat is accepted, output_enable=0, val/size/flush=0, done=1 for one cycle, return to IDLE.
- Handshake:
  - A beat is accepted on a rising edge where output_enable && out_ready.
  - On acceptance, the next beat is presented on the following cycle, with no bubble.
  - While output_enable && !out_ready, val, size_of_bit and flush_bit hold stable, and the field index does not advance.
  - Stall length is unbounded.
- Header length: 7 beats (8 with FLUSH_AT_END=1). With out_ready held at 1, done rises 8 (or 9) cycles after the start edge.
- busy is high in EMIT and FLUSH, and low in IDLE and during the done cycle.
- Start while not IDLE: the request is ignored, start_err pulses for one cycle, and the latched config is unchanged.
- Start in the cycle done is high is accepted (state is IDLE), so back-to-back headers are supported.
- out_ready while output_enable=0 has no effect.
- Latched config is used for the whole header. Input changes after acceptance do not affect emitted values.
- flush_bit is 0 on every field beat.

Decomposition:
- Shared package prores_header_pkg:
  - State enum (IDLE, EMIT, FLUSH).
  - Field-count constant PIC_HDR_FIELDS=7 and field-width constants (5, 3, 32, 16, 2, 2, 4).
  - Pure function pic_hdr_field(index, latched config) returning {val, size}, reused later by the frame-header emitter.
- No sub-module: the FSM, index counter and field mux form one block.

Test Plan:
- Reset, then start with picture_size=0x42E, slice_num=1, log2_slice_mb=3, out_ready=1 -> seven consecutive beats (8,5), (0,3), (0x42E,32), (1,16), (0,2), (3,2), (0,4); done 8 cycles after start; sum of size_of_bit = 64.
- Same stimulus with out_ready low for 3 cycles during beat 2 -> beat 2 held at (0x42E,32) for 4 cycles; remaining beats unchanged; done delayed by 3 cycles.
- Start pulse during beat 4 with picture_size changed to 0x999 -> start_err pulses once; header completes with the original values; no second header follows.
- FLUSH_AT_END=1, out_ready=1 -> eighth beat (0,0) with flush_bit=1; done 9 cycles after start; flush_bit=0 on all other beats.
- reset_n low during beat 3 -> outputs 0 immediately (asynchronously); after release, a new start emits from beat 0 with the new config.
- Start asserted in the done cycle with slice_num=2 -> second header follows with no idle gap; its beat 3 = (2,16).
